edge_event_arbiter: RTL and testbench
=====================================

# edge_event_arbiter

Samples N asynchronous-ish level inputs, detects rising and falling edges on each, queues them per line, and serializes them onto one valid/ready event stream via round-robin arbitration. Sits between raw inputs (buttons, sensor strobes) and a single downstream consumer, such as a UART logger or a CPU event register. Edges are never merged across lines. A lost edge is flagged per line.

## Interface
- `N`, default 4: number of input lines (≥2).
- `ID_W`, default `$clog2(N)`: width of `out_id`. Derived; do not override.

Ports:
- `clk`, input, 1: single clock. All state is updated on `posedge clk`.
- `rst`, input, 1: asynchronous, active-low reset. Asserts immediately and is released synchronously by the integrator.
- `in`, input, N: level inputs, one per line.
- `out_valid`, output, 1: an event is presented.
- `out_ready`, input, 1: consumer accepts the event this cycle.
- `out_id`, output, ID_W: line index of the presented event.
- `out_rising`, output, 1: 1 means rising edge, 0 means falling edge.
- `overflow`, output, N: sticky per-line lost-edge flags.
- `ovf_clr`, input, 1: one-cycle pulse that clears all `overflow` bits.

## Operation
- Sample stage: `in_q <= in`; `in_prev <= in_q`.
  - rise[i] = in_q[i] & ~in_prev[i]
  - fall[i] = ~in_q[i] & in_prev[i]
- Per-line state:
  - `pend_r[i]` and `pend_f[i]` hold pending rising and falling events.
  - `old_r[i]` records which pending event is older. It is 1 when the pending rise is older.
- Pending set: a detected edge sets its pend bit. If both become pending, `old_r` records order. Rise and fall cannot occur on the same line in the same cycle.
- Overflow: a detected edge whose pend bit is already set and not being granted this cycle drops the edge and sets `overflow[i]`.
  - `overflow` stays set until `ovf_clr`.
  - If `ovf_clr` and a new overflow coincide, overflow wins.
- Output register update: load happens when `!out_valid || out_ready`.
  - Grant the first line with any pending bit, scanning from `last_grant+1` modulo N.
  - Load `out_id` and `out_rising`, then clear that pend bit.
  - If the line has both bits pending, emit the older one and keep the other.
  - Update `last_grant` to the granted line.
  - If nothing is pending, `out_valid` goes to 0.
- Grant-and-new-edge collision: an edge of the same polarity detected in the cycle its pend bit is granted re-sets the pend bit. This is not an overflow.
- Handshake:
  - `out_id` and `out_rising` are stable while `out_valid && !out_ready`.
  - `out_valid` never drops without acceptance.
  - Back-to-back accepts yield one event per cycle.
- Reset values:
  - `out_valid=0`, `out_id=0`, `out_rising=0`, `overflow=0`.
  - All `in_q`, `in_prev`, pend and old bits are 0.
  - `last_grant=N-1`, so line 0 has first priority.
  - An input already high at reset release produces one rising event.
- Reset mid-operation: all pending and presented events are discarded with no partial handshake. `out_valid` drops asynchronously.

## Timing
- `in[i]` rises before edge k:
  - `in_q` is 1 after edge k.
  - `pend_r` is set after edge k+1.
  - `out_valid=1` after edge k+2 if the output stage is free. Latency is 2 cycles, or 4 with the synchronizer below.
- Throughput: 1 event per cycle with `out_ready` held high.
- Minimum input pulse width for guaranteed capture of both edges: 1 clock. Each edge is captured if its pend slot is empty.
- `overflow` updates in the cycle after the offending edge is detected. `ovf_clr` takes effect on the next edge.

## Configuration
- `EDGE_ARB_SYNC_EN` defined:
  - A two-flop synchronizer per line is inserted before `in_q`.
  - Input-to-`out_valid` latency becomes 4 cycles.
  - Synchronizer flops reset to 0.
- Undefined:
  - `in` feeds `in_q` directly.
  - The integrator guarantees `in` is synchronous to `clk`.

## Test plan
- Reset, then a pulse on `in[2]` lasting 3 cycles with `out_ready=1`:
  - rising event, `out_id=2`, `out_valid` 2 cycles after the rise;
  - falling event, `out_id=2`, 3 cycles later;
  - `overflow=0`.
- Lines 0, 1 and 3 rise in the same cycle with `out_ready=1`: events are emitted as id 0, 1, 3 on consecutive cycles.
- A further rise on line 0 then yields id 0 again only after line 3, showing the round-robin pointer.
- Hold `out_ready=0` for 10 cycles with an event presented:
  - `out_valid`, `out_id` and `out_rising` are stable throughout;
  - after release, exactly one accept per ready cycle.
- With `out_ready=0`, toggle `in[1]` as rise, fall, rise:
  - `overflow[1]=1`;
  - after `out_ready=1`, line 1 emits rise then fall, and the third edge is lost;
  - `ovf_clr` pulse then gives `overflow=0`.
- Assert `rst` low mid-stream with `out_valid=1`:
  - `out_valid=0` immediately;
  - after release, only edges detected post-reset are emitted, including a rise for any input held high.

Source files
------------

// File: rtl/edge_event_arbiter.sv
// Per-line rise/fall edge detector feeding a round-robin valid/ready event stream, with sticky per-line lost-edge flags.
// Latency: input change to out_valid is 2 cycles, or 4 cycles when EDGE_ARB_SYNC_EN adds a 2-flop synchronizer per line.
// Backpressure: out_id/out_rising hold while out_valid && !out_ready; edges queue per line and overflow when a slot is occupied.
module edge_event_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ID_W-1:0] out_id,
  output logic            out_rising,
  output logic [N-1:0]    overflow,
  input  logic            ovf_clr
);

  logic [N-1:0]    in_s;
  logic [N-1:0]    in_q;
  logic [N-1:0]    in_prev;
  logic [N-1:0]    rise;
  logic [N-1:0]    fall;
  logic [N-1:0]    pend_r;
  logic [N-1:0]    pend_f;
  logic [N-1:0]    old_r;
  logic [N-1:0]    pend_any;
  logic [N-1:0]    pend_r_n;
  logic [N-1:0]    pend_f_n;
  logic [N-1:0]    old_r_n;
  logic [N-1:0]    pr_keep;
  logic [N-1:0]    pf_keep;
  logic [N-1:0]    ovf_evt;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] gnt_idx;
  logic            gnt_vld;
  logic            gnt_rise;
  logic            load;

`ifdef EDGE_ARB_SYNC_EN
  logic [N-1:0] sync1;
  logic [N-1:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign in_s = sync2;
`else
  assign in_s = in;
`endif

  assign rise     = in_q & ~in_prev;
  assign fall     = ~in_q & in_prev;
  assign pend_any = pend_r | pend_f;
  assign load     = !out_valid || out_ready;

  // Round-robin scan starting one past the last granted line.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 1; k <= N; k++) begin
      if (!gnt_vld && pend_any[(int'(last_grant) + k) % N]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'((int'(last_grant) + k) % N);
      end
    end
  end

  // With both polarities pending, the older one goes first.
  assign gnt_rise = pend_r[gnt_idx] & (~pend_f[gnt_idx] | old_r[gnt_idx]);

  always_comb begin
    pr_keep  = '0;
    pf_keep  = '0;
    pend_r_n = '0;
    pend_f_n = '0;
    old_r_n  = '0;
    ovf_evt  = '0;
    for (int i = 0; i < N; i++) begin
      pr_keep[i]  = pend_r[i] & ~(load & gnt_vld & (gnt_idx == ID_W'(i)) & gnt_rise);
      pf_keep[i]  = pend_f[i] & ~(load & gnt_vld & (gnt_idx == ID_W'(i)) & ~gnt_rise);
      pend_r_n[i] = pr_keep[i] | rise[i];
      pend_f_n[i] = pf_keep[i] | fall[i];
      // A slot being drained this cycle may be refilled without counting as a loss.
      ovf_evt[i]  = (rise[i] & pr_keep[i]) | (fall[i] & pf_keep[i]);
      if (rise[i] && !pr_keep[i] && pf_keep[i])
        old_r_n[i] = 1'b0;
      else if (fall[i] && !pf_keep[i] && pr_keep[i])
        old_r_n[i] = 1'b1;
      else
        old_r_n[i] = old_r[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q       <= '0;
      in_prev    <= '0;
      pend_r     <= '0;
      pend_f     <= '0;
      old_r      <= '0;
      overflow   <= '0;
      out_valid  <= 1'b0;
      out_id     <= '0;
      out_rising <= 1'b0;
      last_grant <= ID_W'(N - 1);
    end else begin
      in_q     <= in_s;
      in_prev  <= in_q;
      pend_r   <= pend_r_n;
      pend_f   <= pend_f_n;
      old_r    <= old_r_n;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_evt;
      if (load) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          out_id     <= gnt_idx;
          out_rising <= gnt_rise;
          last_grant <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter: expected events queued at stimulus time, popped by a negedge monitor on each accept.
module tb_edge_event_arbiter;
  localparam int N    = 4;
  localparam int ID_W = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            rising;
  } ev_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N-1:0]    in = '0;
  logic            out_ready = 1'b0;
  logic            ovf_clr = 1'b0;
  logic            out_valid;
  logic [ID_W-1:0] out_id;
  logic            out_rising;
  logic [N-1:0]    overflow;

  ev_t exp_q[$];
  ev_t mon_e;
  int  n_checks = 0;
  int  n_fail   = 0;
  int  n_acc    = 0;
  int  acc0;

  edge_event_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_id    (out_id),
    .out_rising(out_rising),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int id, input logic r);
    ev_t e;
    e.id     = ID_W'(id);
    e.rising = r;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the next expected event.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      n_acc++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got id=%0d rising=%0b with no event expected at %0t", out_id, out_rising, $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_id", 32'(out_id), 32'(mon_e.id));
        chk("sb_dir", 32'(out_rising), 32'(mon_e.rising));
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_id", 32'(out_id), 0);
    chk("rst_rising", 32'(out_rising), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b1;

    // Pulse on line 2 for 3 cycles; in changes before edge k, out_valid after edge k+2.
    out_ready = 1'b1;
    in = 4'b0100; push(2, 1'b1);
    tick(1); chk("t1_lat_k", 32'(out_valid), 0);
    tick(1); chk("t1_lat_k1", 32'(out_valid), 0);
    tick(1); chk("t1_rise_vld", 32'(out_valid), 1);
    chk("t1_rise_id", 32'(out_id), 2);
    chk("t1_rise_dir", 32'(out_rising), 1);
    in = 4'b0000; push(2, 1'b0);
    tick(1); chk("t1_gap0", 32'(out_valid), 0);
    tick(1); chk("t1_gap1", 32'(out_valid), 0);
    tick(1); chk("t1_fall_vld", 32'(out_valid), 1);
    chk("t1_fall_id", 32'(out_id), 2);
    chk("t1_fall_dir", 32'(out_rising), 0);
    chk("t1_ovf", 32'(overflow), 0);

    // Line 3 pulse leaves the round-robin pointer on line 3.
    in = 4'b1000; push(3, 1'b1);
    tick(4);
    in = 4'b0000; push(3, 1'b0);
    tick(6);

    // Lines 0,1,3 rise together: one event per cycle in order 0,1,3.
    in = 4'b1011; push(0, 1'b1); push(1, 1'b1); push(3, 1'b1);
    tick(3); chk("t2_first_vld", 32'(out_valid), 1);
    chk("t2_first_id", 32'(out_id), 0);
    tick(1); chk("t2_second_id", 32'(out_id), 1);
    tick(1); chk("t2_third_id", 32'(out_id), 3);
    tick(3);

    // Grant line 0, then line 0 and line 3 pend together: line 3 goes first.
    in = 4'b1010; push(0, 1'b0);
    tick(5);
    in = 4'b0011; push(3, 1'b0); push(0, 1'b1);
    tick(3); chk("rr_first_id", 32'(out_id), 3);
    chk("rr_first_dir", 32'(out_rising), 0);
    tick(1); chk("rr_second_id", 32'(out_id), 0);
    chk("rr_second_dir", 32'(out_rising), 1);
    tick(3);

    // Stall for 10 cycles with an event presented and another queued.
    out_ready = 1'b0;
    in = 4'b0001; push(1, 1'b0);
    tick(3); chk("stall_pres_vld", 32'(out_valid), 1);
    in = 4'b0000; push(0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      tick(1);
      chk("stall_vld", 32'(out_valid), 1);
      chk("stall_id", 32'(out_id), 1);
      chk("stall_dir", 32'(out_rising), 0);
    end
    acc0 = n_acc;
    out_ready = 1'b1;
    tick(1); chk("accept_one", 32'(n_acc), 32'(acc0 + 1));
    chk("accept_next_id", 32'(out_id), 0);
    tick(1); chk("accept_two", 32'(n_acc), 32'(acc0 + 2));
    tick(3);

    // Line 2 holds the output; line 1 toggles rise, fall, rise so the last rise is lost.
    out_ready = 1'b0;
    in = 4'b0100; push(2, 1'b1);
    tick(4); chk("ovf_hold_id", 32'(out_id), 2);
    in = 4'b0110; push(1, 1'b1);
    tick(1);
    in = 4'b0100; push(1, 1'b0);
    tick(1);
    in = 4'b0110;
    tick(3); chk("ovf_set", 32'(overflow), 32'h2);
    out_ready = 1'b1;
    tick(6); chk("ovf_sticky", 32'(overflow), 32'h2);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    chk("ovf_clear", 32'(overflow), 0);

    // Reset with an event presented: it is discarded; held-high lines re-emit rises.
    out_ready = 1'b0;
    in = 4'b0111;
    tick(4); chk("pre_rst_vld", 32'(out_valid), 1);
    #2 rst = 1'b0;
    #1 chk("rst_async_vld", 32'(out_valid), 0);
    chk("rst_async_ovf", 32'(overflow), 0);
    tick(2);
    rst = 1'b1;
    out_ready = 1'b1;
    push(0, 1'b1); push(1, 1'b1); push(2, 1'b1);
    tick(3); chk("post_rst_first", 32'(out_id), 0);
    tick(5);
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
